ysyx_22041752_ifu_axi_bridge: RTL and testbench

//  Upstream of the IF stage: turns the IF stage's SRAM-style fetch port (inst_en/inst_addr/inst_ready/inst_rdata)

---
 rtl/ysyx_22041752_ifu_axi_bridge.sv | 150 +++++++++++++++
 tb/tb_ysyx_22041752_ifu_axi_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_ifu_axi_bridge.sv
// IF-stage fetch port to single-outstanding AXI4-Lite read master (AR/R only).
// Optional IFU_BRIDGE_PERF_EN adds fetch/stall performance counters.
module ysyx_22041752_ifu_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic              inst_ready,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_err,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
`ifdef IFU_BRIDGE_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AR   = 2'd1;
    localparam logic [1:0] R    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              sel_q, sel_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              pulse_q, pulse_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              accept;
    logic [31:0]       word;

    assign inst_ready  = (state_q == IDLE);
    assign accept      = inst_en && inst_ready;
    assign inst_rvalid = pulse_q;
    assign inst_rdata  = rdata_q;
    assign inst_err    = err_q;
    assign araddr      = araddr_q;
    assign arprot      = 3'b100;
    assign arvalid     = arvalid_q;
    assign rready      = rready_q;
    assign word        = sel_q ? rdata[63:32] : rdata[31:0];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        drop_d    = drop_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        pulse_d   = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_d = inst_addr[2];
                    if (|inst_addr[1:0]) begin
                        pulse_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        araddr_d  = {inst_addr[ADDR_W-1:3], 3'b000};
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end
                end
            end
            AR: begin
                if (inst_cancel) drop_d = 1'b1;
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (inst_cancel) drop_d = 1'b1;
                if (rvalid && rready_q) begin
                    rready_d = 1'b0;
                    state_d  = IDLE;
                    drop_d   = 1'b0;
                    // a cancel landing on the handshake cycle still kills this beat
                    if (!(drop_q || inst_cancel)) begin
                        pulse_d = 1'b1;
                        rdata_d = {{(DATA_W-32){1'b0}}, word};
                        err_d   = (rresp != 2'b00);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            drop_q    <= 1'b0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            pulse_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            drop_q    <= drop_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            pulse_q   <= pulse_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

`ifdef IFU_BRIDGE_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pulse_d) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (state_q != IDLE) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22041752_ifu_axi_bridge.sv
// Directed + randomized bench for the IFU AXI bridge with a transaction-level model.
// Define IFU_BRIDGE_PERF_EN to also check the performance counters.
module tb_ysyx_22041752_ifu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        inst_ready;
    logic        inst_rvalid;
    logic [63:0] inst_rdata;
    logic        inst_err;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
`ifdef IFU_BRIDGE_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    logic [63:0] exp_rdata = '0;
    logic        exp_err   = 1'b0;
    int          exp_fetch = 0;
    int          exp_stall = 0;

    always #5 clk = ~clk;

    ysyx_22041752_ifu_axi_bridge #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_en     (inst_en),
        .inst_addr   (inst_addr),
        .inst_cancel (inst_cancel),
        .inst_ready  (inst_ready),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .inst_err    (inst_err),
        .araddr      (araddr),
        .arprot      (arprot),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready)
`ifdef IFU_BRIDGE_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf();
`ifdef IFU_BRIDGE_PERF_EN
        chk("perf_fetch", {32'b0, perf_fetch_cnt}, 64'(exp_fetch));
        chk("perf_stall", {32'b0, perf_stall_cnt}, 64'(exp_stall));
`endif
    endtask

    // Runs one fetch; called and returns at a negedge with the bridge idle.
    // cx: busy-cycle index where cancel pulses, -1 none, -2 with the request.
    task automatic fetch(input logic [31:0] a, input int ard, input int rd,
                         input logic [63:0] d, input logic [1:0] rs,
                         input int cx, input bit noise);
        int cyc;
        bit cancelled;
        cyc = 0;
        chk("idle_ready", {63'b0, inst_ready}, 64'd1);
        inst_en     = 1'b1;
        inst_addr   = a;
        inst_cancel = (cx == -2);
        @(negedge clk);
        inst_en     = 1'b0;
        inst_cancel = 1'b0;
        if (a[1:0] != 2'b00) begin
            exp_rdata = '0;
            exp_err   = 1'b1;
            exp_fetch++;
            chk("mis_rvalid", {63'b0, inst_rvalid}, 64'd1);
            chk("mis_err", {63'b0, inst_err}, 64'd1);
            chk("mis_rdata", inst_rdata, 64'd0);
            chk("mis_arvalid", {63'b0, arvalid}, 64'd0);
            chk_perf();
            @(negedge clk);
            chk("mis_pulse_end", {63'b0, inst_rvalid}, 64'd0);
            return;
        end
        for (int i = 0; i <= ard; i++) begin
            chk("ar_valid", {63'b0, arvalid}, 64'd1);
            chk("ar_addr", {32'b0, araddr}, {32'b0, a[31:3], 3'b000});
            chk("ar_prot", {61'b0, arprot}, 64'd4);
            chk("ar_busy", {62'b0, inst_ready, inst_rvalid}, 64'd0);
            arready     = (i == ard);
            inst_cancel = (cyc == cx);
            if (noise) begin
                inst_en   = 1'($urandom);
                inst_addr = $urandom;
            end
            cyc++;
            @(negedge clk);
        end
        arready = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            chk("r_state", {61'b0, arvalid, rready, inst_ready}, 64'b010);
            chk("r_no_pulse", {63'b0, inst_rvalid}, 64'd0);
            rvalid      = (i == rd);
            rdata       = (i == rd) ? d : 64'($urandom);
            rresp       = rs;
            inst_cancel = (cyc == cx);
            if (noise) begin
                inst_en   = 1'($urandom);
                inst_addr = $urandom;
            end
            cyc++;
            @(negedge clk);
        end
        rvalid      = 1'b0;
        inst_cancel = 1'b0;
        inst_en     = 1'b0;
        exp_stall  += cyc;
        cancelled   = (cx >= 0) && (cx < cyc);
        if (!cancelled) begin
            exp_rdata = {32'b0, a[2] ? d[63:32] : d[31:0]};
            exp_err   = (rs != 2'b00);
            exp_fetch++;
        end
        chk("resp_rvalid", {63'b0, inst_rvalid}, {63'b0, !cancelled});
        chk("resp_rdata", inst_rdata, exp_rdata);
        chk("resp_err", {63'b0, inst_err}, {63'b0, exp_err});
        chk("resp_idle", {62'b0, inst_ready, rready}, 64'b10);
        chk_perf();
        @(negedge clk);
        chk("pulse_end", {63'b0, inst_rvalid}, 64'd0);
        chk("hold_rdata", inst_rdata, exp_rdata);
    endtask

    initial begin
        logic [31:0] a;
        int          cx;
        reset       = 1'b1;
        inst_en     = 1'b0;
        inst_addr   = '0;
        inst_cancel = 1'b0;
        arready     = 1'b0;
        rdata       = '0;
        rresp       = 2'b00;
        rvalid      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {63'b0, inst_ready}, 64'd1);
        chk("rst_outs", {60'b0, arvalid, rready, inst_rvalid, inst_err}, 64'd0);
        chk("rst_rdata", inst_rdata, 64'd0);
        chk("rst_araddr", {32'b0, araddr}, 64'd0);
        chk_perf();

        fetch(32'h8000_0004, 0, 0, 64'h1122_3344_5566_7788, 2'b00, -1, 0);
        chk("t1_word", inst_rdata, 64'h0000_0000_1122_3344);
        fetch(32'h8000_0010, 5, 2, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, -1, 1);
        fetch(32'h8000_0020, 1, 2, 64'hDEAD_BEEF_0BAD_F00D, 2'b00, 3, 0);
        fetch(32'h8000_0100, 0, 1, 64'h0102_0304_0506_0708, 2'b00, -1, 0);
        chk("t3_word", inst_rdata, 64'h0000_0000_0506_0708);
        fetch(32'h8000_0008, 0, 0, 64'h1234_5678_9ABC_DEF0, 2'b10, -1, 0);
        chk("t4_err", {63'b0, inst_err}, 64'd1);
        fetch(32'h8000_0018, 1, 1, 64'h5555_6666_7777_8888, 2'b00, 3, 0);
        fetch(32'h8000_0030, 2, 0, 64'h9999_AAAA_BBBB_CCCC, 2'b00, 0, 0);
        fetch(32'h8000_0002, 0, 0, 64'h0, 2'b00, -1, 0);
        fetch(32'h8000_0044, 0, 0, 64'hFACE_CAFE_0000_1111, 2'b00, -2, 0);

        inst_en   = 1'b1;
        inst_addr = 32'h8000_0040;
        @(negedge clk);
        inst_en = 1'b0;
        chk("t6_in_ar", {63'b0, arvalid}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        exp_fetch = 0;
        exp_stall = 0;
        chk("t6_ready", {63'b0, inst_ready}, 64'd1);
        chk("t6_outs", {60'b0, arvalid, rready, inst_rvalid, inst_err}, 64'd0);
        chk("t6_rdata", inst_rdata, 64'd0);
        chk("t6_araddr", {32'b0, araddr}, 64'd0);
        chk_perf();

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            cx = int'($urandom_range(0, 11)) - 6;
            if (cx < -2) cx = -1;
            fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 2'($urandom), cx, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
